// File: rtl/credit_arbiter_pkg.sv
// credit_arbiter_pkg
// Shared constants and helpers for the credit-based two-way arbiter in front of
// shared_resource. No ports; imported by the interface, the order FIFO and the
// arbiter top.
package credit_arbiter_pkg;

  // Requester encodings, also used as the address/id mux select value.
  localparam logic ARB_REQ_1 = 1'b0;
  localparam logic ARB_REQ_2 = 1'b1;

  // Default sizing of the arbiter.
  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int DEFAULT_ORDER_DEPTH     = 8;

  // Existing bus widths of the shared_resource path (not used by the arbiter).
  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 4;
  localparam int DATA_WIDTH    = 32;

  // Credit counters are always 4 bits wide (MAX_OUTSTANDING is 1..15).
  localparam int CREDIT_WIDTH = 4;
  typedef logic [CREDIT_WIDTH-1:0] credit_t;

  // Round-robin: after a grant the other requester gets priority.
  function automatic logic other_req(input logic req);
    return ~req;
  endfunction

endpackage

// File: rtl/credit_arbiter_if.sv
// credit_arbiter_if
// Bundles the arbiter's request/response handshake and status signals.
//   in_valid_1/2     requester has a request at its pipeline tail
//   in_ready         shared_resource accepts a request this cycle
//   in_resp_valid    shared_resource returns an in-order response
//   out_valid        request issued this cycle
//   out_choice       granted requester / mux select (0 = req 1, 1 = req 2)
//   out_stall_1/2    hold the corresponding pipeline
//   out_resp_choice  owner of the current response
//   out_credits_1/2  remaining credits per requester
//   out_error        sticky: response seen with nothing outstanding
// Modport master drives the inputs (pipelines/resource side), slave is the arbiter.
interface credit_arbiter_if;
  import credit_arbiter_pkg::*;

  logic    in_valid_1;
  logic    in_valid_2;
  logic    in_ready;
  logic    in_resp_valid;
  logic    out_valid;
  logic    out_choice;
  logic    out_stall_1;
  logic    out_stall_2;
  logic    out_resp_choice;
  credit_t out_credits_1;
  credit_t out_credits_2;
  logic    out_error;

  modport master (
    output in_valid_1, in_valid_2, in_ready, in_resp_valid,
    input  out_valid, out_choice, out_stall_1, out_stall_2,
    input  out_resp_choice, out_credits_1, out_credits_2, out_error
  );

  modport slave (
    input  in_valid_1, in_valid_2, in_ready, in_resp_valid,
    output out_valid, out_choice, out_stall_1, out_stall_2,
    output out_resp_choice, out_credits_1, out_credits_2, out_error
  );

endinterface

// File: rtl/credit_arbiter_order_fifo.sv
// credit_arbiter_order_fifo
// 1-bit wide in-order FIFO recording which requester owns each issued request.
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write push_data_i (accepted when not full, or when popping)
//   push_data_i   owner of the issued request
//   pop_i         retire the head entry (ignored when empty)
//   head_o        head entry, 0 when empty
//   count_o       number of stored entries (0..DEPTH)
module credit_arbiter_order_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     push_data_i,
  input  logic                     pop_i,
  output logic                     head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees the slot being written, so a full FIFO
  // may still accept a push; the head is read before the edge overwrites it.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q == '0) ? 1'b0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/credit_arbiter.sv
// credit_arbiter
// Round-robin two-way arbiter gated by per-requester outstanding credits, with
// an in-order FIFO attributing each shared_resource response to its requester.
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    credit_arbiter_if.slave: requests, ready, responses in; grant,
//          mux select, stalls, response owner, credits and error out
module credit_arbiter
  import credit_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ORDER_DEPTH     = DEFAULT_ORDER_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  credit_arbiter_if.slave  bus
);

  localparam int      CW         = $clog2(ORDER_DEPTH) + 1;
  localparam credit_t CREDIT_MAX = CREDIT_WIDTH'(MAX_OUTSTANDING);

  logic          ptr_q;
  logic          ptr_d;
  logic          error_q;
  logic [CW-1:0] count;
  logic          head;
  logic          pop;
  logic          space;
  logic          grant;
  logic          sel;
  logic          choice;
  logic [1:0]    valid;
  logic [1:0]    elig;
  logic [1:0][CREDIT_WIDTH-1:0] credits;

  assign valid = {bus.in_valid_2, bus.in_valid_1};

  // Popping this cycle frees a slot, so a full FIFO does not block a grant.
  assign pop   = bus.in_resp_valid && (count != '0);
  assign space = (count < CW'(ORDER_DEPTH)) || bus.in_resp_valid;

  always_comb begin
    sel = ptr_q;
    if (elig == 2'b11)  sel = ptr_q;
    else if (elig[0])   sel = ARB_REQ_1;
    else if (elig[1])   sel = ARB_REQ_2;
  end

  assign grant  = bus.in_ready && space && (elig != 2'b00);
  // Idle cycles present the priority pointer on the mux select.
  assign choice = grant ? sel : ptr_q;
  assign ptr_d  = grant ? other_req(choice) : ptr_q;

  // Per-requester credit counters.
  for (genvar gi = 0; gi < 2; gi++) begin : g_credit
    credit_t credit_q;
    credit_t credit_d;
    logic    dec;
    logic    inc;

    assign elig[gi] = valid[gi] && (credit_q != '0);
    assign dec      = grant && (choice == 1'(gi));
    // Only a real pop returns a credit; responses with an empty FIFO do not.
    assign inc      = pop && (head == 1'(gi));

    always_comb begin
      credit_d = credit_q;
      if (dec && !inc)
        credit_d = credit_q - 1'b1;
      else if (inc && !dec && (credit_q != CREDIT_MAX))
        credit_d = credit_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) credit_q <= CREDIT_MAX;
      else       credit_q <= credit_d;
    end

    assign credits[gi] = credit_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= ARB_REQ_1;
      error_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (bus.in_resp_valid && (count == '0)) error_q <= 1'b1;
    end
  end

  credit_arbiter_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (grant),
    .push_data_i (choice),
    .pop_i       (bus.in_resp_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.out_valid       = grant;
  assign bus.out_choice      = choice;
  assign bus.out_stall_1     = bus.in_valid_1 && !(grant && (choice == ARB_REQ_1));
  assign bus.out_stall_2     = bus.in_valid_2 && !(grant && (choice == ARB_REQ_2));
  assign bus.out_resp_choice = head;
  assign bus.out_credits_1   = credits[0];
  assign bus.out_credits_2   = credits[1];
  assign bus.out_error       = error_q;

endmodule

// File: tb/tb_credit_arbiter.sv
// tb_credit_arbiter
// Directed bench for credit_arbiter: a default instance (MAX 4, depth 8) and a
// depth-2 instance that reaches a full FIFO while credits remain.
module tb_credit_arbiter;

  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;

  credit_arbiter_if bus ();
  credit_arbiter_if bus_b ();

  credit_arbiter #(
    .MAX_OUTSTANDING (4),
    .ORDER_DEPTH     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  credit_arbiter #(
    .MAX_OUTSTANDING (4),
    .ORDER_DEPTH     (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic v2, input logic rdy, input logic resp);
    bus.in_valid_1    = v1;
    bus.in_valid_2    = v2;
    bus.in_ready      = rdy;
    bus.in_resp_valid = resp;
    #1;
  endtask

  task automatic drive_b(input logic v1, input logic v2, input logic rdy, input logic resp);
    bus_b.in_valid_1    = v1;
    bus_b.in_valid_2    = v2;
    bus_b.in_ready      = rdy;
    bus_b.in_resp_valid = resp;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);

    // Test 1: reset state, then alternating grants with a response every cycle.
    do_reset();
    check("rst_credits_1", bus.out_credits_1, 4);
    check("rst_credits_2", bus.out_credits_2, 4);
    check("rst_error", bus.out_error, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_choice", bus.out_choice, 0);
    check("rst_resp_choice", bus.out_resp_choice, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, i > 0);
      $display("t1 cycle %0d: valid=%0d choice=%0d cr1=%0d cr2=%0d resp_choice=%0d",
               i, bus.out_valid, bus.out_choice, bus.out_credits_1,
               bus.out_credits_2, bus.out_resp_choice);
      check("t1_valid", bus.out_valid, 1);
      check("t1_choice", bus.out_choice, i % 2);
      check("t1_credits_1", bus.out_credits_1, (i % 2 == 1) ? 3 : 4);
      check("t1_credits_2", bus.out_credits_2, (i > 0 && i % 2 == 0) ? 3 : 4);
      if (i > 0) check("t1_resp_choice", bus.out_resp_choice, (i - 1) % 2);
      tick();
    end
    drive(0, 0, 0, 1);
    check("t1_drain_resp_choice", bus.out_resp_choice, 1);
    tick();
    drive(0, 0, 0, 0);
    check("t1_error", bus.out_error, 0);
    check("t1_end_credits_1", bus.out_credits_1, 4);
    check("t1_end_credits_2", bus.out_credits_2, 4);

    // Test 2: requester 1 alone exhausts its credits, then one response.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0);
      $display("t2 cycle %0d: valid=%0d choice=%0d cr1=%0d", i, bus.out_valid,
               bus.out_choice, bus.out_credits_1);
      check("t2_valid", bus.out_valid, 1);
      check("t2_choice", bus.out_choice, 0);
      check("t2_credits_1", bus.out_credits_1, 4 - i);
      check("t2_stall_1", bus.out_stall_1, 0);
      tick();
    end
    drive(1, 0, 1, 0);
    check("t2_exhausted_valid", bus.out_valid, 0);
    check("t2_exhausted_stall_1", bus.out_stall_1, 1);
    check("t2_stall_2_idle", bus.out_stall_2, 0);
    check("t2_exhausted_credits_1", bus.out_credits_1, 0);
    check("t2_idle_choice_ptr", bus.out_choice, 1);
    tick();
    drive(1, 0, 1, 1);
    check("t2_resp_choice", bus.out_resp_choice, 0);
    check("t2_resp_cycle_valid", bus.out_valid, 0);
    tick();
    drive(1, 0, 1, 0);
    $display("t2 after response: valid=%0d cr1=%0d", bus.out_valid, bus.out_credits_1);
    check("t2_returned_credits_1", bus.out_credits_1, 1);
    check("t2_regrant_valid", bus.out_valid, 1);
    check("t2_regrant_choice", bus.out_choice, 0);

    // Test 3: fill the depth-8 FIFO, then a response frees requester 1 only.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 0);
      check("t3_fill_choice", bus.out_choice, i % 2);
      tick();
    end
    drive(1, 1, 1, 0);
    $display("t3 full: valid=%0d stall1=%0d stall2=%0d", bus.out_valid,
             bus.out_stall_1, bus.out_stall_2);
    check("t3_full_valid", bus.out_valid, 0);
    check("t3_full_stall_1", bus.out_stall_1, 1);
    check("t3_full_stall_2", bus.out_stall_2, 1);
    check("t3_full_credits_2", bus.out_credits_2, 0);
    tick();
    drive(0, 1, 1, 1);
    check("t3_resp_choice", bus.out_resp_choice, 0);
    check("t3_resp_valid", bus.out_valid, 0);
    tick();
    drive(0, 0, 0, 0);
    check("t3_after_credits_1", bus.out_credits_1, 1);
    check("t3_after_credits_2", bus.out_credits_2, 0);

    // Test 3b: depth-2 instance, full FIFO with a same-cycle pop and grant.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_b(0, 1, 1, 0);
      check("t3b_fill_valid", bus_b.out_valid, 1);
      check("t3b_fill_choice", bus_b.out_choice, 1);
      tick();
    end
    drive_b(0, 1, 1, 0);
    check("t3b_full_valid", bus_b.out_valid, 0);
    check("t3b_full_stall_2", bus_b.out_stall_2, 1);
    tick();
    drive_b(0, 1, 1, 1);
    $display("t3b pop+push at full: valid=%0d choice=%0d resp_choice=%0d cr2=%0d",
             bus_b.out_valid, bus_b.out_choice, bus_b.out_resp_choice,
             bus_b.out_credits_2);
    check("t3b_popgrant_valid", bus_b.out_valid, 1);
    check("t3b_popgrant_choice", bus_b.out_choice, 1);
    check("t3b_popgrant_resp_choice", bus_b.out_resp_choice, 1);
    check("t3b_popgrant_credits_2", bus_b.out_credits_2, 2);
    tick();
    drive_b(0, 1, 1, 0);
    check("t3b_still_full_valid", bus_b.out_valid, 0);
    check("t3b_unchanged_credits_2", bus_b.out_credits_2, 2);
    tick();
    drive_b(0, 0, 0, 0);

    // Test 4: in_ready low holds the pointer.
    do_reset();
    drive(1, 0, 1, 0);
    check("t4_first_choice", bus.out_choice, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      $display("t4 not ready %0d: valid=%0d choice=%0d", i, bus.out_valid, bus.out_choice);
      check("t4_hold_valid", bus.out_valid, 0);
      check("t4_hold_stall_1", bus.out_stall_1, 1);
      check("t4_hold_stall_2", bus.out_stall_2, 1);
      check("t4_hold_choice", bus.out_choice, 1);
      tick();
    end
    drive(1, 1, 1, 0);
    check("t4_resume_valid", bus.out_valid, 1);
    check("t4_resume_choice", bus.out_choice, 1);
    check("t4_resume_stall_1", bus.out_stall_1, 1);
    check("t4_resume_stall_2", bus.out_stall_2, 0);
    tick();

    // Test 5: response with an empty FIFO sets the sticky error.
    do_reset();
    drive(0, 0, 0, 1);
    check("t5_error_before_edge", bus.out_error, 0);
    check("t5_resp_choice_empty", bus.out_resp_choice, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      $display("t5 cycle %0d: error=%0d cr1=%0d cr2=%0d", i, bus.out_error,
               bus.out_credits_1, bus.out_credits_2);
      check("t5_error_sticky", bus.out_error, 1);
      check("t5_credits_1", bus.out_credits_1, 4);
      check("t5_credits_2", bus.out_credits_2, 4);
      tick();
    end

    // Test 6: asynchronous reset mid-stream with count=5, credits_1=1.
    do_reset();
    check("t6_error_cleared", bus.out_error, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0);
      tick();
    end
    drive(1, 1, 1, 0);
    check("t6_pre_credits_1", bus.out_credits_1, 1);
    check("t6_pre_credits_2", bus.out_credits_2, 2);
    check("t6_pre_choice", bus.out_choice, 1);
    check("t6_pre_resp_choice", bus.out_resp_choice, 1);
    reset = 1'b1;
    #1;
    $display("t6 async reset: cr1=%0d cr2=%0d choice=%0d resp_choice=%0d",
             bus.out_credits_1, bus.out_credits_2, bus.out_choice, bus.out_resp_choice);
    check("t6_rst_credits_1", bus.out_credits_1, 4);
    check("t6_rst_credits_2", bus.out_credits_2, 4);
    check("t6_rst_choice", bus.out_choice, 0);
    check("t6_rst_resp_choice", bus.out_resp_choice, 0);
    check("t6_rst_error", bus.out_error, 0);
    #1;
    reset = 1'b0;
    #1;
    check("t6_release_valid", bus.out_valid, 1);
    check("t6_release_choice", bus.out_choice, 0);
    tick();
    drive(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
